// File: rtl/tlb_lookup_ctrl_pkg.sv
// Shared geometry, state encoding and permission helpers for the TLB lookup controller.
package tlb_lookup_ctrl_pkg;

    localparam int TLB_NUM_SETS       = 16;
    localparam int TLB_NUM_WAYS       = 4;
    localparam int TLB_SET_INDEX_BITS = 4;
    localparam int TLB_LRU_BITS       = 2;
    localparam int TLB_WAY_BITS       = 2;
    localparam int TLB_VPN_W          = 20;
    localparam int TLB_PPN_W          = 20;
    localparam int PERM_R             = 0;
    localparam int PERM_W             = 1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOOKUP    = 4'd1,
        ST_WALK_REQ  = 4'd2,
        ST_WALK_WAIT = 4'd3,
        ST_FILL      = 4'd4,
        ST_AGE       = 4'd5,
        ST_RESP      = 4'd6,
        ST_FLUSH     = 4'd7,
        ST_FLUSH_END = 4'd8
    } state_t;

    // A store needs the write bit, anything else needs the read bit.
    function automatic logic perm_fault(input logic is_write, input logic [1:0] perms);
        return is_write ? ~perms[PERM_W] : ~perms[PERM_R];
    endfunction

endpackage

// File: rtl/tlb_victim_sel.sv
// Replacement choice for a full or partly-filled set: first free way, else the oldest way.
module tlb_victim_sel
    import tlb_lookup_ctrl_pkg::*;
#(
    parameter int NUM_WAYS = TLB_NUM_WAYS,
    parameter int LRU_BITS = TLB_LRU_BITS
) (
    input  logic                    i_rd_valid     [0:NUM_WAYS-1],
    input  logic [LRU_BITS-1:0]     i_rd_lru_count [0:NUM_WAYS-1],
    output logic [TLB_WAY_BITS-1:0] o_victim_way,
    output logic                    o_victim_valid
);

    logic                    w_found_inv;
    logic [TLB_WAY_BITS-1:0] w_inv_way;
    logic [TLB_WAY_BITS-1:0] w_max_way;
    logic [LRU_BITS-1:0]     w_max_cnt;

    always_comb begin
        w_found_inv = 1'b0;
        w_inv_way   = '0;
        w_max_way   = '0;
        w_max_cnt   = i_rd_lru_count[0];
        // Descending scan so the lowest free index is the one left standing.
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!i_rd_valid[w]) begin
                w_found_inv = 1'b1;
                w_inv_way   = TLB_WAY_BITS'(w);
            end
        end
        // Strict compare keeps the lowest index on equal counts.
        for (int w = 1; w < NUM_WAYS; w++) begin
            if (i_rd_lru_count[w] > w_max_cnt) begin
                w_max_cnt = i_rd_lru_count[w];
                w_max_way = TLB_WAY_BITS'(w);
            end
        end
    end

    assign o_victim_way   = w_found_inv ? w_inv_way : w_max_way;
    assign o_victim_valid = ~w_found_inv;

endmodule

// File: rtl/tlb_lookup_ctrl.sv
// TLB lookup controller: tag compare, LRU aging, walk-and-fill on miss, and full flush.
module tlb_lookup_ctrl
    import tlb_lookup_ctrl_pkg::*;
#(
    parameter int NUM_SETS       = TLB_NUM_SETS,
    parameter int NUM_WAYS       = TLB_NUM_WAYS,
    parameter int SET_INDEX_BITS = TLB_SET_INDEX_BITS,
    parameter int LRU_BITS       = TLB_LRU_BITS
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_va,
    input  logic                      req_is_write,

    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_pa,
    output logic                      resp_fault,
    output logic                      resp_hit,

    input  logic                      flush_valid,
    output logic                      flush_done,

    output logic                      walk_req_valid,
    input  logic                      walk_req_ready,
    output logic [TLB_VPN_W-1:0]      walk_req_vpn,
    input  logic                      walk_resp_valid,
    input  logic [TLB_PPN_W-1:0]      walk_resp_ppn,
    input  logic [1:0]                walk_resp_perms,
    input  logic                      walk_resp_fault,

    output logic [SET_INDEX_BITS-1:0] rd_set_index,
    input  logic                      rd_valid     [0:NUM_WAYS-1],
    input  logic [TLB_VPN_W-1:0]      rd_vpn       [0:NUM_WAYS-1],
    input  logic [TLB_PPN_W-1:0]      rd_ppn       [0:NUM_WAYS-1],
    input  logic [1:0]                rd_perms     [0:NUM_WAYS-1],
    input  logic [LRU_BITS-1:0]       rd_lru_count [0:NUM_WAYS-1],

    output logic                      wr_en,
    output logic [SET_INDEX_BITS-1:0] wr_set_index,
    output logic [TLB_WAY_BITS-1:0]   wr_way,
    output logic                      wr_valid,
    output logic [TLB_VPN_W-1:0]      wr_vpn,
    output logic [TLB_PPN_W-1:0]      wr_ppn,
    output logic [1:0]                wr_perms,
    output logic [LRU_BITS-1:0]       wr_lru_count,

    output logic                      lru_update_en,
    output logic [SET_INDEX_BITS-1:0] lru_set_index,
    output logic [TLB_WAY_BITS-1:0]   lru_way,
    output logic [LRU_BITS-1:0]       lru_value
);

    localparam int WB  = TLB_WAY_BITS;
    localparam int FCW = SET_INDEX_BITS + WB;

    state_t                    r_state;
    state_t                    w_next;
    logic [31:0]               r_va;
    logic                      r_is_write;
    logic [TLB_PPN_W-1:0]      r_ppn;
    logic [1:0]                r_perms;
    logic [LRU_BITS-1:0]       r_old;
    logic [WB-1:0]             r_way;
    logic [WB-1:0]             r_age_idx;
    logic [FCW-1:0]            r_flush_cnt;
    logic [31:0]               r_resp_pa;
    logic                      r_resp_fault;
    logic                      r_resp_hit;

    logic [TLB_VPN_W-1:0]      w_vpn;
    logic [SET_INDEX_BITS-1:0] w_set;
    logic [SET_INDEX_BITS-1:0] w_flush_set;
    logic [WB-1:0]             w_flush_way;
    logic                      w_hit;
    logic [WB-1:0]             w_hit_way;
    logic [WB-1:0]             w_victim_way;
    logic                      w_victim_valid;
    logic                      w_age_upd;
    logic                      w_flush_last;

    assign w_vpn        = r_va[31:12];
    assign w_set        = w_vpn[SET_INDEX_BITS-1:0];
    assign w_flush_set  = r_flush_cnt[FCW-1:WB];
    assign w_flush_way  = r_flush_cnt[WB-1:0];
    assign w_flush_last = (r_flush_cnt == FCW'(NUM_SETS * NUM_WAYS - 1));

    assign walk_req_vpn = w_vpn;
    assign resp_pa      = r_resp_pa;
    assign resp_fault   = r_resp_fault;
    assign resp_hit     = r_resp_hit;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (rd_valid[w] && (rd_vpn[w] == w_vpn)) begin
                w_hit     = 1'b1;
                w_hit_way = WB'(w);
            end
        end
    end

    tlb_victim_sel #(
        .NUM_WAYS (NUM_WAYS),
        .LRU_BITS (LRU_BITS)
    ) u_victim_sel (
        .i_rd_valid     (rd_valid),
        .i_rd_lru_count (rd_lru_count),
        .o_victim_way   (w_victim_way),
        .o_victim_valid (w_victim_valid)
    );

    // Ways younger than the touched entry's old age get one step older; the touched way is skipped.
    assign w_age_upd = (r_age_idx != r_way) && rd_valid[r_age_idx] &&
                       (rd_lru_count[r_age_idx] < r_old);

    always_comb begin
        w_next         = r_state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        flush_done     = 1'b0;
        walk_req_valid = 1'b0;
        rd_set_index   = w_set;
        wr_en          = 1'b0;
        wr_set_index   = '0;
        wr_way         = '0;
        wr_valid       = 1'b0;
        wr_vpn         = '0;
        wr_ppn         = '0;
        wr_perms       = '0;
        wr_lru_count   = '0;
        lru_update_en  = 1'b0;
        lru_set_index  = '0;
        lru_way        = '0;
        lru_value      = '0;
        case (r_state)
            ST_IDLE: begin
                req_ready = ~flush_valid;
                if (flush_valid) begin
                    w_next = ST_FLUSH;
                end else if (req_valid) begin
                    w_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    lru_update_en = 1'b1;
                    lru_set_index = w_set;
                    lru_way       = w_hit_way;
                    w_next        = ST_AGE;
                end else begin
                    w_next = ST_WALK_REQ;
                end
            end
            ST_WALK_REQ: begin
                walk_req_valid = 1'b1;
                if (walk_req_ready) begin
                    w_next = ST_WALK_WAIT;
                end
            end
            ST_WALK_WAIT: begin
                if (walk_resp_valid) begin
                    w_next = walk_resp_fault ? ST_RESP : ST_FILL;
                end
            end
            ST_FILL: begin
                wr_en        = 1'b1;
                wr_set_index = w_set;
                wr_way       = w_victim_way;
                wr_valid     = 1'b1;
                wr_vpn       = w_vpn;
                wr_ppn       = r_ppn;
                wr_perms     = r_perms;
                w_next       = ST_AGE;
            end
            ST_AGE: begin
                if (w_age_upd) begin
                    lru_update_en = 1'b1;
                    lru_set_index = w_set;
                    lru_way       = r_age_idx;
                    lru_value     = rd_lru_count[r_age_idx] + LRU_BITS'(1);
                end
                if (r_age_idx == WB'(NUM_WAYS - 1)) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                rd_set_index = w_flush_set;
                wr_en        = 1'b1;
                wr_set_index = w_flush_set;
                wr_way       = w_flush_way;
                if (w_flush_last) begin
                    w_next = ST_FLUSH_END;
                end
            end
            ST_FLUSH_END: begin
                flush_done = 1'b1;
                w_next     = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_va         <= '0;
            r_is_write   <= 1'b0;
            r_ppn        <= '0;
            r_perms      <= '0;
            r_old        <= '0;
            r_way        <= '0;
            r_age_idx    <= '0;
            r_flush_cnt  <= '0;
            r_resp_pa    <= '0;
            r_resp_fault <= 1'b0;
            r_resp_hit   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    r_age_idx   <= '0;
                    r_flush_cnt <= '0;
                    if (!flush_valid && req_valid) begin
                        r_va       <= req_va;
                        r_is_write <= req_is_write;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        r_way        <= w_hit_way;
                        r_old        <= rd_lru_count[w_hit_way];
                        r_ppn        <= rd_ppn[w_hit_way];
                        r_perms      <= rd_perms[w_hit_way];
                        r_resp_pa    <= {rd_ppn[w_hit_way], r_va[11:0]};
                        r_resp_fault <= perm_fault(r_is_write, rd_perms[w_hit_way]);
                        r_resp_hit   <= 1'b1;
                    end
                end
                ST_WALK_WAIT: begin
                    if (walk_resp_valid) begin
                        r_resp_hit <= 1'b0;
                        if (walk_resp_fault) begin
                            r_resp_pa    <= '0;
                            r_resp_fault <= 1'b1;
                        end else begin
                            r_ppn        <= walk_resp_ppn;
                            r_perms      <= walk_resp_perms;
                            r_resp_pa    <= {walk_resp_ppn, r_va[11:0]};
                            r_resp_fault <= perm_fault(r_is_write, walk_resp_perms);
                        end
                    end
                end
                ST_FILL: begin
                    r_way <= w_victim_way;
                    // A free slot counts as oldest so every valid way ages.
                    r_old <= w_victim_valid ? rd_lru_count[w_victim_way] : '1;
                end
                ST_AGE: begin
                    r_age_idx <= r_age_idx + WB'(1);
                end
                ST_FLUSH: begin
                    r_flush_cnt <= r_flush_cnt + FCW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Directed bench for tlb_lookup_ctrl with a behavioural storage array and a scripted walker.
module tb_tlb_lookup_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_va;
    logic        req_is_write;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_pa;
    logic        resp_fault;
    logic        resp_hit;
    logic        flush_valid;
    logic        flush_done;
    logic        walk_req_valid;
    logic        walk_req_ready;
    logic [19:0] walk_req_vpn;
    logic        walk_resp_valid;
    logic [19:0] walk_resp_ppn;
    logic [1:0]  walk_resp_perms;
    logic        walk_resp_fault;
    logic [3:0]  rd_set_index;
    logic        rd_valid     [0:3];
    logic [19:0] rd_vpn       [0:3];
    logic [19:0] rd_ppn       [0:3];
    logic [1:0]  rd_perms     [0:3];
    logic [1:0]  rd_lru_count [0:3];
    logic        wr_en;
    logic [3:0]  wr_set_index;
    logic [1:0]  wr_way;
    logic        wr_valid;
    logic [19:0] wr_vpn;
    logic [19:0] wr_ppn;
    logic [1:0]  wr_perms;
    logic [1:0]  wr_lru_count;
    logic        lru_update_en;
    logic [3:0]  lru_set_index;
    logic [1:0]  lru_way;
    logic [1:0]  lru_value;

    int checks;
    int failures;

    // Storage model
    logic        m_clear;
    logic        m_valid [0:15][0:3];
    logic [19:0] m_vpn   [0:15][0:3];
    logic [19:0] m_ppn   [0:15][0:3];
    logic [1:0]  m_perms [0:15][0:3];
    logic [1:0]  m_lru   [0:15][0:3];

    // Per-transaction observations
    int          t_walks;
    logic [19:0] t_walk_vpn;
    int          t_wr_cnt;
    int          t_lru_cnt;
    int          t_conflict;
    int          t_lat;
    logic        t_done;
    logic [31:0] t_pa;
    logic        t_fault;
    logic        t_hit;

    tlb_lookup_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_va          (req_va),
        .req_is_write    (req_is_write),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_pa         (resp_pa),
        .resp_fault      (resp_fault),
        .resp_hit        (resp_hit),
        .flush_valid     (flush_valid),
        .flush_done      (flush_done),
        .walk_req_valid  (walk_req_valid),
        .walk_req_ready  (walk_req_ready),
        .walk_req_vpn    (walk_req_vpn),
        .walk_resp_valid (walk_resp_valid),
        .walk_resp_ppn   (walk_resp_ppn),
        .walk_resp_perms (walk_resp_perms),
        .walk_resp_fault (walk_resp_fault),
        .rd_set_index    (rd_set_index),
        .rd_valid        (rd_valid),
        .rd_vpn          (rd_vpn),
        .rd_ppn          (rd_ppn),
        .rd_perms        (rd_perms),
        .rd_lru_count    (rd_lru_count),
        .wr_en           (wr_en),
        .wr_set_index    (wr_set_index),
        .wr_way          (wr_way),
        .wr_valid        (wr_valid),
        .wr_vpn          (wr_vpn),
        .wr_ppn          (wr_ppn),
        .wr_perms        (wr_perms),
        .wr_lru_count    (wr_lru_count),
        .lru_update_en   (lru_update_en),
        .lru_set_index   (lru_set_index),
        .lru_way         (lru_way),
        .lru_value       (lru_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int w = 0; w < 4; w++) begin
            rd_valid[w]     = m_valid[rd_set_index][w];
            rd_vpn[w]       = m_vpn[rd_set_index][w];
            rd_ppn[w]       = m_ppn[rd_set_index][w];
            rd_perms[w]     = m_perms[rd_set_index][w];
            rd_lru_count[w] = m_lru[rd_set_index][w];
        end
    end

    always @(posedge clk) begin
        if (m_clear) begin
            for (int s = 0; s < 16; s++) begin
                for (int w = 0; w < 4; w++) begin
                    m_valid[s][w] <= 1'b0;
                    m_vpn[s][w]   <= '0;
                    m_ppn[s][w]   <= '0;
                    m_perms[s][w] <= '0;
                    m_lru[s][w]   <= '0;
                end
            end
        end else begin
            if (wr_en) begin
                m_valid[wr_set_index][wr_way] <= wr_valid;
                m_vpn[wr_set_index][wr_way]   <= wr_vpn;
                m_ppn[wr_set_index][wr_way]   <= wr_ppn;
                m_perms[wr_set_index][wr_way] <= wr_perms;
                m_lru[wr_set_index][wr_way]   <= wr_lru_count;
            end
            if (lru_update_en) begin
                m_lru[lru_set_index][lru_way] <= lru_value;
            end
        end
    end

    // Issues one request from IDLE, plays the walker, and accepts the response.
    task automatic run_req(input logic [31:0] va, input logic wr, input logic [19:0] wppn,
                           input logic [1:0] wperms, input logic wfault);
        logic hs_pending;
        hs_pending = 1'b0;
        t_walks    = 0;
        t_walk_vpn = '0;
        t_wr_cnt   = 0;
        t_lru_cnt  = 0;
        t_conflict = 0;
        t_lat      = 0;
        t_done     = 1'b0;
        t_pa       = '0;
        t_fault    = 1'b0;
        t_hit      = 1'b0;
        req_valid    = 1'b1;
        req_va       = va;
        req_is_write = wr;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) req_valid = 1'b0;
            walk_resp_valid = 1'b0;
            if (hs_pending) begin
                hs_pending      = 1'b0;
                walk_req_ready  = 1'b0;
                walk_resp_valid = 1'b1;
                walk_resp_ppn   = wppn;
                walk_resp_perms = wperms;
                walk_resp_fault = wfault;
            end else if (walk_req_valid) begin
                t_walks++;
                t_walk_vpn     = walk_req_vpn;
                walk_req_ready = 1'b1;
                hs_pending     = 1'b1;
            end
            if (wr_en) t_wr_cnt++;
            if (lru_update_en) t_lru_cnt++;
            if (wr_en && lru_update_en) t_conflict++;
            if (resp_valid) begin
                t_lat      = n;
                t_pa       = resp_pa;
                t_fault    = resp_fault;
                t_hit      = resp_hit;
                resp_ready = 1'b1;
                @(posedge clk);
                #1;
                resp_ready = 1'b0;
                t_done     = 1'b1;
                break;
            end
        end
        checks++;
        if (t_done !== 1'b1) begin
            failures++;
            $display("FAIL resp_timeout va=%h: no response within budget", va);
        end
    endtask

    task automatic test_reset();
        m_clear = 1'b1;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_clear = 1'b0;
        rst     = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, walk_req_valid, wr_en, lru_update_en, flush_done, resp_fault, resp_hit}
            !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=10000000",
                     {req_ready, resp_valid, walk_req_valid, wr_en, lru_update_en, flush_done, resp_fault, resp_hit});
        end
        checks++;
        if ({resp_pa, walk_req_vpn} !== 52'h0) begin
            failures++;
            $display("FAIL reset_data pa=%h vpn=%h exp 0", resp_pa, walk_req_vpn);
        end
    endtask

    task automatic test_cold_miss();
        run_req(32'h12345ABC, 1'b0, 20'h00077, 2'b01, 1'b0);
        checks++;
        if (t_walks !== 1 || t_walk_vpn !== 20'h12345) begin
            failures++;
            $display("FAIL cold_walk walks=%0d vpn=%h exp 1/12345", t_walks, t_walk_vpn);
        end
        checks++;
        if (t_pa !== 32'h00077ABC) begin
            failures++;
            $display("FAIL cold_pa got=%h exp=00077abc", t_pa);
        end
        checks++;
        if ({t_hit, t_fault} !== 2'b00) begin
            failures++;
            $display("FAIL cold_flags hit/fault=%b exp=00", {t_hit, t_fault});
        end
        checks++;
        if (t_wr_cnt !== 1 || t_conflict !== 0) begin
            failures++;
            $display("FAIL cold_writes wr=%0d conflict=%0d exp 1/0", t_wr_cnt, t_conflict);
        end
        checks++;
        if ({m_valid[5][0], m_vpn[5][0], m_ppn[5][0], m_perms[5][0], m_lru[5][0]}
            !== {1'b1, 20'h12345, 20'h00077, 2'b01, 2'b00}) begin
            failures++;
            $display("FAIL cold_entry v=%b vpn=%h ppn=%h perms=%b cnt=%0d exp 1/12345/00077/01/0",
                     m_valid[5][0], m_vpn[5][0], m_ppn[5][0], m_perms[5][0], m_lru[5][0]);
        end
    endtask

    task automatic test_hit_write();
        run_req(32'h12345ABC, 1'b1, 20'h0, 2'b00, 1'b0);
        checks++;
        if (t_walks !== 0 || t_wr_cnt !== 0) begin
            failures++;
            $display("FAIL hit_nowalk walks=%0d wr=%0d exp 0/0", t_walks, t_wr_cnt);
        end
        checks++;
        if (t_lat !== 6) begin
            failures++;
            $display("FAIL hit_latency got=%0d exp=6", t_lat);
        end
        checks++;
        if ({t_hit, t_fault} !== 2'b11 || t_pa !== 32'h00077ABC) begin
            failures++;
            $display("FAIL hit_resp hit/fault=%b pa=%h exp 11/00077abc", {t_hit, t_fault}, t_pa);
        end
    endtask

    task automatic test_lru_victim();
        for (int i = 0; i < 4; i++) begin
            run_req({16'h0000 + 16'(i), 4'h3, 12'h000}, 1'b0, 20'h00100 + 20'(i), 2'b11, 1'b0);
        end
        checks++;
        if ({m_lru[3][0], m_lru[3][1], m_lru[3][2], m_lru[3][3]} !== 8'b11_10_01_00) begin
            failures++;
            $display("FAIL lru_after_fills got=%b exp=11100100",
                     {m_lru[3][0], m_lru[3][1], m_lru[3][2], m_lru[3][3]});
        end
        run_req(32'h00003456, 1'b0, 20'h0, 2'b00, 1'b0);
        checks++;
        if ({t_hit, t_fault} !== 2'b10 || t_pa !== 32'h00100456 || t_walks !== 0) begin
            failures++;
            $display("FAIL lru_rehit hit/fault=%b pa=%h walks=%0d exp 10/00100456/0",
                     {t_hit, t_fault}, t_pa, t_walks);
        end
        checks++;
        if ({m_lru[3][0], m_lru[3][1], m_lru[3][2], m_lru[3][3]} !== 8'b00_11_10_01) begin
            failures++;
            $display("FAIL lru_after_hit got=%b exp=00111001",
                     {m_lru[3][0], m_lru[3][1], m_lru[3][2], m_lru[3][3]});
        end
        run_req(32'h00043010, 1'b1, 20'h00104, 2'b11, 1'b0);
        checks++;
        if ({t_hit, t_fault} !== 2'b00 || t_pa !== 32'h00104010 || t_conflict !== 0) begin
            failures++;
            $display("FAIL evict_resp hit/fault=%b pa=%h conflict=%0d exp 00/00104010/0",
                     {t_hit, t_fault}, t_pa, t_conflict);
        end
        checks++;
        if (m_vpn[3][1] !== 20'h00043 || m_vpn[3][0] !== 20'h00003) begin
            failures++;
            $display("FAIL evict_way way1=%h way0=%h exp 00043/00003", m_vpn[3][1], m_vpn[3][0]);
        end
        checks++;
        if ({m_lru[3][0], m_lru[3][1], m_lru[3][2], m_lru[3][3]} !== 8'b01_00_11_10) begin
            failures++;
            $display("FAIL lru_after_evict got=%b exp=01001110",
                     {m_lru[3][0], m_lru[3][1], m_lru[3][2], m_lru[3][3]});
        end
    endtask

    task automatic test_walk_fault();
        run_req(32'h99995123, 1'b0, 20'h00555, 2'b11, 1'b1);
        checks++;
        if ({t_hit, t_fault} !== 2'b01 || t_pa !== 32'h0) begin
            failures++;
            $display("FAIL wfault_resp hit/fault=%b pa=%h exp 01/00000000", {t_hit, t_fault}, t_pa);
        end
        checks++;
        if (t_wr_cnt !== 0 || t_lru_cnt !== 0 || t_walks !== 1) begin
            failures++;
            $display("FAIL wfault_ports wr=%0d lru=%0d walks=%0d exp 0/0/1", t_wr_cnt, t_lru_cnt, t_walks);
        end
        checks++;
        if ({m_valid[5][0], m_vpn[5][0], m_lru[5][0], m_valid[5][1]} !== {1'b1, 20'h12345, 2'b00, 1'b0}) begin
            failures++;
            $display("FAIL wfault_set v0=%b vpn0=%h cnt0=%0d v1=%b exp 1/12345/0/0",
                     m_valid[5][0], m_vpn[5][0], m_lru[5][0], m_valid[5][1]);
        end
    endtask

    task automatic test_flush();
        int wr_cnt;
        int last_wr;
        int done_n;
        logic any_valid;
        wr_cnt  = 0;
        last_wr = 0;
        done_n  = 0;
        flush_valid  = 1'b1;
        req_valid    = 1'b1;
        req_va       = 32'h00043000;
        req_is_write = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_prio req_ready=%b exp=0", req_ready);
        end
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                flush_valid = 1'b0;
                req_valid   = 1'b0;
            end
            if (wr_en) begin
                wr_cnt++;
                last_wr = n;
            end
            if (flush_done) begin
                done_n = n;
                break;
            end
        end
        checks++;
        if (wr_cnt !== 64 || done_n !== 65 || last_wr !== 64) begin
            failures++;
            $display("FAIL flush_timing writes=%0d done_at=%0d last_wr=%0d exp 64/65/64", wr_cnt, done_n, last_wr);
        end
        @(posedge clk);
        #1;
        any_valid = 1'b0;
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 4; w++) begin
                any_valid = any_valid | m_valid[s][w];
            end
        end
        checks++;
        if (any_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_cleared some entry valid=%b exp=0", any_valid);
        end
        run_req(32'h00043000, 1'b0, 20'h00222, 2'b01, 1'b0);
        checks++;
        if (t_hit !== 1'b0 || t_walks !== 1 || t_pa !== 32'h00222000) begin
            failures++;
            $display("FAIL flush_remiss hit=%b walks=%0d pa=%h exp 0/1/00222000", t_hit, t_walks, t_pa);
        end
    endtask

    task automatic test_reset_abort();
        logic seen;
        int   stray;
        seen  = 1'b0;
        stray = 0;
        req_valid    = 1'b1;
        req_va       = 32'h0ABCD000;
        req_is_write = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (walk_req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL abort_walkreq walk request not seen");
        end
        walk_req_ready = 1'b1;
        @(posedge clk);
        #1;
        walk_req_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({req_ready, resp_valid, walk_req_valid, wr_en, lru_update_en, flush_done, resp_fault, resp_hit}
            !== 8'b1000_0000 || resp_pa !== 32'h0 || walk_req_vpn !== 20'h0) begin
            failures++;
            $display("FAIL abort_outputs ctrl=%b pa=%h vpn=%h exp 10000000/0/0",
                     {req_ready, resp_valid, walk_req_valid, wr_en, lru_update_en, flush_done, resp_fault, resp_hit},
                     resp_pa, walk_req_vpn);
        end
        walk_resp_valid = 1'b1;
        walk_resp_ppn   = 20'h00999;
        walk_resp_perms = 2'b11;
        walk_resp_fault = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            walk_resp_valid = 1'b0;
            if (wr_en || resp_valid) stray++;
        end
        checks++;
        if (stray !== 0 || m_valid[13][0] !== 1'b0) begin
            failures++;
            $display("FAIL abort_nofill stray=%0d v=%b exp 0/0", stray, m_valid[13][0]);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        m_clear         = 1'b1;
        rst             = 1'b1;
        req_valid       = 1'b0;
        req_va          = '0;
        req_is_write    = 1'b0;
        resp_ready      = 1'b0;
        flush_valid     = 1'b0;
        walk_req_ready  = 1'b0;
        walk_resp_valid = 1'b0;
        walk_resp_ppn   = '0;
        walk_resp_perms = '0;
        walk_resp_fault = 1'b0;
        test_reset();
        test_cold_miss();
        test_hit_write();
        test_lru_victim();
        test_walk_fault();
        test_flush();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
